pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port PCTarget  in  32  redirect address from the branch/jump target adder.
REQ-005 SHALL have port PCSrc  in  1  redirect request, qualifies PCTarget for that cycle.
REQ-006 SHALL have port StallF  in  1  decode cannot accept a new instruction this cycle.
REQ-007 SHALL have port ICacheReady  in  1  I-cache accepts the request this cycle.
REQ-008 SHALL have port ICacheValid  in  1  I-cache returns an instruction this cycle.
REQ-009 SHALL have port ICacheInstr  in  32  returned instruction word.
REQ-010 SHALL have port ICacheReq  out  1  fetch request.
REQ-011 SHALL have port ICacheAddr  out  32  fetch address, equal to fetch_pc.
REQ-012 SHALL have port PC  out  32  registered address of the instruction presented to decode.
REQ-013 SHALL have port InstrF  out  32  registered instruction presented to decode.
REQ-014 SHALL have port InstrValidF  out  1  InstrF/PC hold a live instruction.
REQ-015 SHALL have port PCPlus4F  out  32  combinational PC + 4, modulo 2^32.

Function
REQ-016 SHALL keep internal fetch_pc with bits [1:0] always 00; PCTarget[1:0] ignored on load.
REQ-017 SHALL implement FSM states S_REQ, S_WAIT, S_HOLD, plus pending-redirect flag and address.
REQ-018 S_REQ: ICacheReq = !PCSrc; ICacheReq && ICacheReady -> S_WAIT; PCSrc -> fetch_pc <= PCTarget, stay S_REQ.
REQ-019 S_WAIT: ICacheReq = 0; PCSrc without ICacheValid -> pending flag set, pending address <= PCTarget; a later PCSrc overwrites it.
REQ-020 S_WAIT with ICacheValid and (pending flag or PCSrc): response discarded; fetch_pc <= PCTarget if PCSrc, else pending address; pending cleared; -> S_REQ.
REQ-021 S_WAIT with ICacheValid, no redirect, StallF=0: InstrF <= ICacheInstr, PC <= fetch_pc, InstrValidF <= 1, fetch_pc <= fetch_pc+4, -> S_REQ.
REQ-022 S_WAIT with ICacheValid, no redirect, StallF=1: instruction and fetch_pc captured in hold buffer, -> S_HOLD; decode outputs unchanged.
REQ-023 S_HOLD: PCSrc -> buffer dropped, fetch_pc <= PCTarget, -> S_REQ; else StallF=0 -> buffer delivered as in REQ-021, -> S_REQ; else stay.
REQ-024 SHALL ignore ICacheValid outside S_WAIT and ICacheReady outside S_REQ.
REQ-025 PCSrc=1 SHALL clear InstrValidF next edge regardless of StallF (flush beats stall).
REQ-026 StallF=1 without PCSrc SHALL hold PC, InstrF, InstrValidF.
REQ-027 StallF=0 cycle with no delivery and no PCSrc SHALL clear InstrValidF (instruction consumed).
REQ-028 fetch_pc+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-029 Latency: ICacheValid at edge N -> InstrValidF high after edge N; peak throughput one instruction per two cycles.

Reset
REQ-030 rst_n low SHALL immediately force: state S_REQ, fetch_pc = RESET_PC, PC = RESET_PC, InstrF = 32'h0000_0013, InstrValidF = 0, pending cleared, hold buffer cleared.
REQ-031 Reset assertion mid-transaction SHALL abandon the outstanding request; a late ICacheValid after reset release, in S_REQ, is ignored.
REQ-032 First ICacheReq SHALL assert in the first cycle after rst_n rises, with ICacheAddr = RESET_PC.

Verification
REQ-033 Reset, ICacheReady=1, ICacheValid one cycle after accept, words A,B -> PC 0x0 InstrF A, then PC 0x4 InstrF B, InstrValidF pulses each delivery.
REQ-034 PCSrc=1, PCTarget=0x0000_0103 in S_WAIT; ICacheValid two cycles later -> word discarded, InstrValidF stays 0, next ICacheAddr = 0x0000_0100.
REQ-035 StallF=1 when ICacheValid arrives, held 3 cycles -> S_HOLD, no ICacheReq, PC/InstrF unchanged; StallF drop -> buffered word delivered next edge.
REQ-036 PCSrc and StallF both 1 with InstrValidF=1 -> InstrValidF=0 next edge, ICacheAddr = PCTarget.
REQ-037 RESET_PC=32'hFFFF_FFFC, one fetch -> PC = 0xFFFF_FFFC, PCPlus4F = 0x0, next ICacheAddr = 0x0.
REQ-038 rst_n pulsed low while in S_WAIT -> outputs at reset values within the same cycle; stray ICacheValid after release ignored.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: one I-cache request in flight, redirects drained as responses return.
// Latency: response edge -> decode registers on the same edge; StallF parks a returned word in a hold buffer.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCTarget,
    input  logic        PCSrc,
    input  logic        StallF,
    input  logic        ICacheReady,
    input  logic        ICacheValid,
    input  logic [31:0] ICacheInstr,
    output logic        ICacheReq,
    output logic [31:0] ICacheAddr,
    output logic [31:0] PC,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic [31:0] PCPlus4F
);

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_fetch_pc, r_pend_addr, r_hold_instr, r_hold_pc;
    logic [31:0] r_pc, r_instr;
    logic        r_pend, r_instr_vld;

    logic [31:0] w_target;
    logic        w_rsp_wait, w_redir_wait, w_deliver_wait, w_capture, w_deliver_hold;
    logic        w_icache_req;

    assign w_target       = {PCTarget[31:2], 2'b00};
    assign w_rsp_wait     = (r_state == S_WAIT) && ICacheValid;
    assign w_redir_wait   = r_pend || PCSrc;
    assign w_deliver_wait = w_rsp_wait && !w_redir_wait && !StallF;
    assign w_capture      = w_rsp_wait && !w_redir_wait && StallF;
    assign w_deliver_hold = (r_state == S_HOLD) && !PCSrc && !StallF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_REQ;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ:   if (!PCSrc && ICacheReady) w_state_nxt = S_WAIT;
            S_WAIT:  if (ICacheValid)           w_state_nxt = w_capture ? S_HOLD : S_REQ;
            S_HOLD:  if (PCSrc || !StallF)      w_state_nxt = S_REQ;
            default:                            w_state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        w_icache_req = 1'b0;
        if (r_state == S_REQ) w_icache_req = !PCSrc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC_AL;
        end else begin
            case (r_state)
                S_REQ: if (PCSrc) r_fetch_pc <= w_target;
                S_WAIT: begin
                    if (ICacheValid) begin
                        if (PCSrc)        r_fetch_pc <= w_target;
                        else if (r_pend)  r_fetch_pc <= r_pend_addr;
                        else if (!StallF) r_fetch_pc <= r_fetch_pc + 32'd4;
                    end
                end
                S_HOLD: begin
                    if (PCSrc)        r_fetch_pc <= w_target;
                    else if (!StallF) r_fetch_pc <= r_hold_pc + 32'd4;
                end
                default: r_fetch_pc <= r_fetch_pc;
            endcase
        end
    end

    // Redirects seen while a response is outstanding are parked until that response is drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_addr <= 32'd0;
        end else if (r_state == S_WAIT) begin
            if (ICacheValid) begin
                r_pend <= 1'b0;
            end else if (PCSrc) begin
                r_pend      <= 1'b1;
                r_pend_addr <= w_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 32'd0;
        end else if (w_capture) begin
            r_hold_instr <= ICacheInstr;
            r_hold_pc    <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC_AL;
            r_instr     <= NOP_INSTR;
            r_instr_vld <= 1'b0;
        end else if (PCSrc) begin
            r_instr_vld <= 1'b0;
        end else if (w_deliver_wait) begin
            r_pc        <= r_fetch_pc;
            r_instr     <= ICacheInstr;
            r_instr_vld <= 1'b1;
        end else if (w_deliver_hold) begin
            r_pc        <= r_hold_pc;
            r_instr     <= r_hold_instr;
            r_instr_vld <= 1'b1;
        end else if (!StallF) begin
            r_instr_vld <= 1'b0;
        end
    end

    assign ICacheReq   = w_icache_req;
    assign ICacheAddr  = r_fetch_pc;
    assign PC          = r_pc;
    assign InstrF      = r_instr;
    assign InstrValidF = r_instr_vld;
    assign PCPlus4F    = r_pc + 32'd4;

endmodule
